// File: rtl/cpu_pkg.sv
// Definitions shared by the multicycle controller, the datapath and the memory bus interface.
package cpu_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } bus_state_t;

  // Opcodes decoded by the controller.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/mem_timeout_counter.sv
// 8-bit wait counter for the bus interface watchdog; flags when the programmed limit is reached.
module mem_timeout_counter #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic at_limit
);

  logic [7:0] count;

  assign at_limit = (count == LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && !at_limit) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/mem_bus_interface.sv
// Converts controller memory strobes into a handshaked 16-bit bus access, loading IR or MDR
// on read completion and pulsing done (and err on timeout or an illegal request).
module mem_bus_interface
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = WORD_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              iord,
  input  logic              ir_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              read_m,
  output logic              write_m,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              input_ready,
  input  logic              ack_output,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  bus_state_t state, state_next;
  logic       target_ir;
  logic       at_limit;
  logic       rd_req, wr_req, bad_req;
  logic       rd_hs, wr_hs, timeout_abort;

  assign rd_req  = mem_read & ~mem_write;
  assign wr_req  = mem_write & ~mem_read;
  assign bad_req = mem_read & mem_write;

  // input_ready only counts in RD and ack_output only in WR.
  assign rd_hs = (state == RD) && input_ready;
  assign wr_hs = (state == WR) && ack_output;

  // A handshake on the limit cycle wins over the watchdog.
  assign timeout_abort = busy && at_limit && !(rd_hs || wr_hs);

  // Strobes are decoded from the state register alone, never from inputs.
  assign read_m  = (state == RD);
  assign write_m = (state == WR);
  assign bus_oe  = (state == WR);
  assign busy    = (state == RD) || (state == WR);
  assign done    = (state == DONE);

  mem_timeout_counter #(
    .LIMIT (8'(TIMEOUT))
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (!busy),
    .enable   (busy),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (rd_req) state_next = RD;
               else if (wr_req) state_next = WR;
      RD:      if (input_ready || at_limit) state_next = DONE;
      WR:      if (ack_output || at_limit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every register here has a reset value, so an abandoned access leaves nothing stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address   <= '0;
      bus_wdata <= '0;
      target_ir <= 1'b0;
      ir        <= '0;
      mdr       <= '0;
      err       <= 1'b0;
    end else begin
      err <= ((state == IDLE) && bad_req) || timeout_abort;
      if ((state == IDLE) && (rd_req || wr_req)) address <= iord ? alu_addr : pc;
      if ((state == IDLE) && rd_req) target_ir <= ir_write;
      if ((state == IDLE) && wr_req) bus_wdata <= wdata;
      if (rd_hs) begin
        if (target_ir) ir  <= bus_rdata;
        else           mdr <= bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_interface.sv
// Self-checking bench for mem_bus_interface: directed fetch/load/store/timeout/illegal/reset
// scenarios plus randomized accesses, checked against a cycle-count model of the bus protocol.
module tb_mem_bus_interface;

  localparam int TIMEOUT = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read, mem_write, iord, ir_write;
  logic [15:0] pc, alu_addr, wdata;
  logic        read_m, write_m, bus_oe;
  logic [15:0] address, bus_wdata;
  logic [15:0] bus_rdata;
  logic        input_ready, ack_output;
  logic [15:0] ir, mdr;
  logic        busy, done, err;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_ir = 16'h0;
  logic [15:0] exp_mdr = 16'h0;

  mem_bus_interface #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc          (pc),
    .alu_addr    (alu_addr),
    .wdata       (wdata),
    .read_m      (read_m),
    .write_m     (write_m),
    .address     (address),
    .bus_wdata   (bus_wdata),
    .bus_oe      (bus_oe),
    .bus_rdata   (bus_rdata),
    .input_ready (input_ready),
    .ack_output  (ack_output),
    .ir          (ir),
    .mdr         (mdr),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // One access from request to the idle cycle after done. lat = wait cycles before the memory
  // answers; lat > TIMEOUT means it never answers.
  task automatic run_txn(input string name, input logic wr, input logic sel, input logic irw,
                         input logic [15:0] pcv, input logic [15:0] aluv,
                         input logic [15:0] wd, input logic [15:0] rd, input int lat);
    logic [15:0] exp_addr;
    logic [5:0]  exp_ctl;
    logic        tmo;
    int          n;
    int          strobes;
    exp_addr = sel ? aluv : pcv;
    tmo      = (lat > TIMEOUT);
    n        = tmo ? TIMEOUT + 1 : lat + 1;
    strobes  = 0;
    @(posedge clk); #1;
    mem_read = !wr; mem_write = wr; iord = sel; ir_write = irw;
    pc = pcv; alu_addr = aluv; wdata = wd;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      pc = 16'($urandom); alu_addr = 16'($urandom); wdata = 16'($urandom);
      iord = 1'($urandom); ir_write = 1'($urandom);
      bus_rdata   = (k == lat) ? rd : 16'($urandom);
      input_ready = wr ? 1'($urandom) : (k == lat);
      ack_output  = wr ? (k == lat) : 1'($urandom);
      @(negedge clk);
      exp_ctl = {!wr, wr, wr, 1'b1, 1'b0, 1'b0};
      if ({read_m, write_m, bus_oe, busy, done, err} !== exp_ctl) begin
        $display("FAIL %s ctl wait %0d: got %b want %b", name, k,
                 {read_m, write_m, bus_oe, busy, done, err}, exp_ctl);
        n_fail++;
      end
      n_checks++;
      if (address !== exp_addr) begin
        $display("FAIL %s address wait %0d: got %h want %h", name, k, address, exp_addr);
        n_fail++;
      end
      n_checks++;
      if (wr && bus_wdata !== wd) begin
        $display("FAIL %s bus_wdata wait %0d: got %h want %h", name, k, bus_wdata, wd);
        n_fail++;
      end
      if (wr) n_checks++;
      if ({ir, mdr} !== {exp_ir, exp_mdr}) begin
        $display("FAIL %s ir/mdr wait %0d: got %h/%h want %h/%h", name, k, ir, mdr, exp_ir, exp_mdr);
        n_fail++;
      end
      n_checks++;
      if (read_m || write_m) strobes++;
    end
    @(posedge clk); #1;
    input_ready = 1'b0; ack_output = 1'b0; bus_rdata = 16'($urandom);
    if (!wr && !tmo) begin
      if (irw) exp_ir = rd;
      else     exp_mdr = rd;
    end
    @(negedge clk);
    exp_ctl = {5'b00001, tmo};
    if ({read_m, write_m, bus_oe, busy, done, err} !== exp_ctl) begin
      $display("FAIL %s done cycle ctl: got %b want %b", name,
               {read_m, write_m, bus_oe, busy, done, err}, exp_ctl);
      n_fail++;
    end
    n_checks++;
    if ({ir, mdr} !== {exp_ir, exp_mdr}) begin
      $display("FAIL %s ir/mdr at done: got %h/%h want %h/%h", name, ir, mdr, exp_ir, exp_mdr);
      n_fail++;
    end
    n_checks++;
    if (strobes !== n) begin
      $display("FAIL %s strobe cycles: got %0d want %0d", name, strobes, n);
      n_fail++;
    end
    n_checks++;
    @(posedge clk); #1;
    @(negedge clk);
    if ({read_m, write_m, bus_oe, busy, done, err} !== 6'b000000) begin
      $display("FAIL %s idle after done: got %b want 000000", name,
               {read_m, write_m, bus_oe, busy, done, err});
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; iord = 1'b0; ir_write = 1'b0;
    pc = 16'h0; alu_addr = 16'h0; wdata = 16'h0;
    bus_rdata = 16'h0; input_ready = 1'b0; ack_output = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if ({read_m, write_m, bus_oe, busy, done, err} !== 6'b000000) begin
      $display("FAIL reset ctl: got %b want 000000", {read_m, write_m, bus_oe, busy, done, err});
      n_fail++;
    end
    n_checks++;
    if ({address, bus_wdata, ir, mdr} !== 64'h0) begin
      $display("FAIL reset regs: got %h %h %h %h want all 0", address, bus_wdata, ir, mdr);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fetch();
    run_txn("fetch", 1'b0, 1'b0, 1'b1, 16'h0010, 16'h5555, 16'h0, 16'hF01C, 3);
  endtask

  task automatic test_load();
    run_txn("load", 1'b0, 1'b1, 1'b0, 16'h7777, 16'h00A4, 16'h0, 16'h1234, 0);
  endtask

  task automatic test_store();
    run_txn("store", 1'b1, 1'b1, 1'b0, 16'h3333, 16'h0042, 16'hBEEF, 16'h0, 2);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 1'b0, 1'b0, 1'b1, 16'h0200, 16'h0, 16'h0, 16'hDEAD, TIMEOUT + 3);
    run_txn("timeout_wr", 1'b1, 1'b1, 1'b0, 16'h0, 16'h0300, 16'hCAFE, 16'h0, TIMEOUT + 1);
    run_txn("hs_at_limit", 1'b0, 1'b1, 1'b0, 16'h0, 16'h0400, 16'h0, 16'h4321, TIMEOUT);
  endtask

  task automatic test_illegal_back_to_back();
    logic [5:0]  ctl_t  [5];
    logic [15:0] ir_t   [5];
    logic [15:0] d1, d2;
    d1 = 16'hA5A1; d2 = 16'h5A52;
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b1; pc = 16'h0123; alu_addr = 16'h0456;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    if ({read_m, write_m, bus_oe, busy, done, err} !== 6'b000001) begin
      $display("FAIL illegal ctl: got %b want 000001", {read_m, write_m, bus_oe, busy, done, err});
      n_fail++;
    end
    n_checks++;
    @(posedge clk); #1;
    @(negedge clk);
    if ({read_m, write_m, bus_oe, busy, done, err} !== 6'b000000) begin
      $display("FAIL illegal after: got %b want 000000", {read_m, write_m, bus_oe, busy, done, err});
      n_fail++;
    end
    n_checks++;
    // Held mem_read: RD, DONE, IDLE (resamples), RD, DONE.
    ctl_t = '{6'b100100, 6'b000010, 6'b000000, 6'b100100, 6'b000010};
    ir_t  = '{exp_ir, d1, d1, d1, d2};
    @(posedge clk); #1;
    mem_read = 1'b1; iord = 1'b0; ir_write = 1'b1; pc = 16'h0AA0;
    input_ready = 1'b1; bus_rdata = d1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin pc = 16'h0BB0; bus_rdata = d2; end
      if (c == 3) mem_read = 1'b0;
      if (c == 4) input_ready = 1'b0;
      @(negedge clk);
      if ({read_m, write_m, bus_oe, busy, done, err} !== ctl_t[c]) begin
        $display("FAIL b2b ctl cycle %0d: got %b want %b", c,
                 {read_m, write_m, bus_oe, busy, done, err}, ctl_t[c]);
        n_fail++;
      end
      n_checks++;
      if (ir !== ir_t[c]) begin
        $display("FAIL b2b ir cycle %0d: got %h want %h", c, ir, ir_t[c]);
        n_fail++;
      end
      n_checks++;
      if ((c == 0 || c == 3) && address !== ((c == 0) ? 16'h0AA0 : 16'h0BB0)) begin
        $display("FAIL b2b address cycle %0d: got %h", c, address);
        n_fail++;
      end
      if (c == 0 || c == 3) n_checks++;
    end
    exp_ir = d2;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic        wr;
    logic [15:0] rd;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom);
      rd = 16'($urandom);
      run_txn("random", wr, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), rd, int'($urandom_range(0, TIMEOUT + 2)));
    end
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    mem_read = 1'b1; iord = 1'b0; ir_write = 1'b1; pc = 16'h0660;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    exp_ir = 16'h0; exp_mdr = 16'h0;
    if ({read_m, write_m, bus_oe, busy, done, err} !== 6'b000000) begin
      $display("FAIL midreset ctl: got %b want 000000", {read_m, write_m, bus_oe, busy, done, err});
      n_fail++;
    end
    n_checks++;
    if ({ir, mdr, address} !== 48'h0) begin
      $display("FAIL midreset regs: got %h %h %h want 0", ir, mdr, address);
      n_fail++;
    end
    n_checks++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) begin
        $display("FAIL midreset done cycle %0d: got %b want 0", c, done);
        n_fail++;
      end
      n_checks++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_txn("refetch", 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0, 16'h0, 16'h8C21, 1);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_timeout();
    test_illegal_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_interface.md
Name: mem_bus_interface

Overview:
- Sits directly downstream of the multicycle controller. It turns the controller's MemRead/MemWrite/lorD/IRWrite strobes into a handshaked transaction on the external 16-bit memory bus.
- Captures returned words into the instruction register (IR) or the memory data register (MDR).
- Emits a one-cycle done pulse so the controller's fetch and memory states can advance on real completion instead of a fixed cycle count.
- Includes a timeout watchdog that flags a bus that never answers.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.
- TIMEOUT, 255, maximum wait cycles in a bus state before abort; counter width is 8 bits, so TIMEOUT must be at most 255.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous reset, active low.
- mem_read  in  1  read request from controller (level).
- mem_write  in  1  write request from controller (level).
- iord  in  1  address select: 0 = pc, 1 = alu_addr.
- ir_write  in  1  when a read completes: 1 = load IR, 0 = load MDR.
- pc  in  ADDR_W  instruction address.
- alu_addr  in  ADDR_W  data address.
- wdata  in  DATA_W  store data (register B).
- read_m  out  1  bus read strobe.
- write_m  out  1  bus write strobe.
- address  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_oe  out  1  drive enable for the external tristate pad.
- bus_rdata  in  DATA_W  bus read data.
- input_ready  in  1  memory: read data valid this cycle.
- ack_output  in  1  memory: write accepted this cycle.
- ir  out  DATA_W  instruction register.
- mdr  out  DATA_W  memory data register.
- busy  out  1  transaction in flight.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse (timeout or illegal request).

Behaviour:
- Reset, asynchronous: all of the following go to 0 immediately: read_m, write_m, address, bus_wdata, bus_oe, ir, mdr, busy, done, err, wait counter. State goes to IDLE.
- Reset asserted mid-transaction: the transaction is abandoned, the bus is released, and no done pulse is issued.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - mem_read=1 and mem_write=0: latch address (pc if iord=0, else alu_addr) and the ir_write target; go to RD.
  - mem_write=1 and mem_read=0: latch address and wdata into bus_wdata; go to WR.
  - Both asserted: no bus access; err=1 for one cycle; stay in IDLE.
  - Neither asserted: stay in IDLE.
- RD:
  - read_m=1, busy=1, address stable.
  - On an edge where input_ready=1: bus_rdata is captured into ir (target=1) or mdr (target=0); go to DONE.
  - The register that is not targeted holds its value.
- WR:
  - write_m=1, bus_oe=1, busy=1, address and bus_wdata stable.
  - On an edge where ack_output=1: go to DONE.
- Minimum latency: a request sampled at edge N enters RD/WR at N; memory can answer in that cycle; DONE is reached at N+1. done is therefore high in cycle N+1 to N+2, a 2-cycle minimum.
- DONE:
  - done=1, busy=0, read_m=write_m=bus_oe=0.
  - Unconditionally returns to IDLE.
- Requests are level-sensitive and sampled only in IDLE. The requester must drop its request during the done cycle; a request still high in IDLE starts a new access (back-to-back accesses are allowed).
- Request changes while in RD or WR are ignored; address and data are held from the latch.
- Timeout:
  - The wait counter clears on entry to RD/WR and increments every cycle without a handshake.
  - When count == TIMEOUT and there is still no handshake: err=1 for one cycle and the state goes to DONE. done also pulses, so the controller unsticks.
  - ir and mdr are unchanged on a timeout.
- Handshake and timeout on the same cycle: the handshake wins; data is captured and err stays 0.
- input_ready in WR and ack_output in RD are ignored.
- Outputs read_m, write_m, bus_oe, busy and done are registered or decoded from state only, with no combinational path from inputs.

Decomposition:
- Shared package (cpu_pkg), to be used later by controller and datapath:
  - state encoding constants IDLE/RD/WR/DONE;
  - WORD_W=16;
  - opcode constants already used by the controller.
- One sub-module, mem_timeout_counter: holds the 8-bit count and provides clear, enable, and a limit-reached flag. Everything else stays in the top module.

Test Plan:
- Fetch: pc=16'h0010, iord=0, ir_write=1, mem_read=1; memory raises input_ready after 3 cycles with 16'hF01C. Required: read_m high for 4 cycles, address=0010, ir=F01C, mdr unchanged, done pulses once.
- Load: iord=1, alu_addr=16'h00A4, ir_write=0; input_ready returns 16'h1234 on the first cycle. Required: mdr=1234, done at the minimum latency of 2 cycles.
- Store: alu_addr=16'h0042, wdata=16'hBEEF, mem_write=1; ack_output after 2 cycles. Required: write_m=bus_oe=1 with address 0042 and bus_wdata BEEF throughout, then done.
- Timeout: TIMEOUT=5, read with no input_ready. Required: err and done pulse together in the cycle after the 6th RD cycle; ir and mdr unchanged; back in IDLE.
- Illegal request plus back-to-back: mem_read=mem_write=1 gives err with no strobe. Then a held mem_read gives two consecutive reads separated by exactly one DONE cycle.
- Reset mid-read: reset_n low while in RD gives read_m=0 and ir=mdr=0 immediately, with no done. After release, a new fetch completes normally.
